// File: rtl/dmem_byte_lsu.sv
// dmem_byte_lsu: serialises RV32I loads/stores onto an 8-bit synchronous-read data memory
module dmem_byte_lsu (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, FIN, RESP} state_t;
    state_t          state, state_nx;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q, wdata_q, ld_ext;
    logic [1:0]      k, last;
    logic [3:0][7:0] lanes, ld_word;
    logic            req_legal, req_mis, req_err, accept, done;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign mem_en     = state == ACCESS;
    assign mem_we     = mem_en && we_q;
    assign mem_addr   = mem_en ? addr_q + {30'd0, k} : 32'd0;
    assign mem_wdata  = mem_we ? wdata_q[{k, 3'b000} +: 8] : 8'd0;

    // request decode, byte sequencing and load-result assembly with extension
    always_comb begin
        req_legal = req_we ? (!req_funct3[2] && req_funct3[1:0] != 2'b11)
                           : (req_funct3[1:0] != 2'b11 && !(req_funct3[2] && req_funct3[1]));
        req_mis   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        req_err   = !req_legal || req_mis;
        accept    = state == IDLE && req_valid;
        last      = f3_q[1] ? 2'd3 : f3_q[0] ? 2'd1 : 2'd0;
        done      = k == last;
        ld_word   = lanes;
        ld_word[last] = mem_rdata;
        ld_ext    = f3_q == 3'b000 ? {{24{ld_word[0][7]}}, ld_word[0]} :
                    f3_q == 3'b001 ? {{16{ld_word[1][7]}}, ld_word[1], ld_word[0]} :
                    f3_q == 3'b100 ? {24'd0, ld_word[0]} :
                    f3_q == 3'b101 ? {16'd0, ld_word[1], ld_word[0]} : ld_word;
    end

    // next-state: errors skip straight to RESP, loads pass through FIN for the last byte
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? (req_err ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = done ? (we_q ? RESP : FIN) : ACCESS;
            FIN:     state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // state register; async reset aborts any access in flight
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) state <= IDLE;
        else           state <= state_nx;
    end

    // request latch, byte index, load lanes and held response registers
    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            k          <= 2'd0;
            lanes      <= '0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                k       <= 2'd0;
                lanes   <= '0;
            end
            if (accept && req_err) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b1;
            end
            if (state == ACCESS) begin
                k <= k + 2'd1;
                if (k != 2'd0) lanes[k - 2'd1] <= mem_rdata;
            end
            if (state == ACCESS && done && we_q) begin
                resp_rdata <= 32'd0;
                resp_err   <= 1'b0;
            end
            if (state == FIN) begin
                resp_rdata <= ld_ext;
                resp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_byte_lsu.sv
// tb_dmem_byte_lsu: directed transactions checked every cycle against a transaction-level model
module tb_dmem_byte_lsu;
    logic        sysclk = 1'b0, sysreset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, mem_en, mem_we;
    logic [31:0] resp_rdata, mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    int passed = 0, total = 0;
    logic        chk_on = 1'b1;
    logic        exp_ready = 1'b1, exp_valid = 1'b0, exp_err = 1'b0, exp_en = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_rdata = 32'd0, exp_addr = 32'd0;
    logic [7:0]  exp_wdata = 8'd0;

    logic [7:0]  mem [0:1023];
    logic        p_en = 1'b0, p_we = 1'b0, pl_en = 1'b0;
    logic [31:0] p_addr = 32'd0, pl_a = 32'd0;
    logic [7:0]  p_wd = 8'd0, pl_d = 8'd0;

    dmem_byte_lsu dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 sysclk = ~sysclk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endfunction

    // byte-wide synchronous-read memory; strobes are sampled mid-cycle, acted on at the edge
    always @(negedge sysclk) begin
        p_en = mem_en; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
    end
    always @(posedge sysclk) begin
        if (pl_en) mem[pl_a[9:0]] = pl_d;
        if (p_en) begin
            if (p_we) mem[p_addr[9:0]] = p_wd;
            else mem_rdata <= mem[p_addr[9:0]];
        end
    end

    // per-cycle compare of every DUT output against the model expectations
    always @(negedge sysclk) if (chk_on) begin
        chk("req_ready", req_ready, exp_ready);
        chk("resp_valid", resp_valid, exp_valid);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", resp_err, exp_err);
        chk("mem_en", mem_en, exp_en);
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
    end

    function automatic int nbytes(logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic is_err(logic we, logic [2:0] f3, logic [31:0] addr);
        logic legal;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || (addr % 32'(nbytes(f3))) != 32'd0;
    endfunction

    function automatic logic [31:0] load_val(logic [2:0] f3, logic [31:0] addr);
        logic [31:0] w, a;
        int n;
        n = nbytes(f3);
        w = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            w = w | (32'(mem[a[9:0]]) << (8 * i));
        end
        if (!f3[2] && n < 4 && w[8 * n - 1]) w = w | (32'hFFFF_FFFF << (8 * n));
        return w;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1;
        @(posedge sysclk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_idle();
        exp_ready = 1'b1; exp_valid = 1'b0; exp_en = 1'b0; exp_we = 1'b0;
        exp_addr = 32'd0; exp_wdata = 8'd0;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic keep,
                        output logic [31:0] rd, output logic er, output int lat);
        int n, cyc, w;
        logic e;
        logic [31:0] v;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(posedge sysclk); #1; w++; end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        e = is_err(we, f3, addr);
        n = nbytes(f3);
        v = (e || we) ? 32'd0 : load_val(f3, addr);
        cyc = e ? 1 : we ? n + 1 : n + 2;
        rd = 32'd0; er = 1'b0; lat = 0;
        @(posedge sysclk); #1;
        if (!keep) req_valid = 1'b0;
        for (int c = 1; c <= cyc; c++) begin
            exp_ready = 1'b0;
            exp_valid = c == cyc;
            exp_en    = !e && c <= n;
            exp_we    = exp_en && we;
            exp_addr  = exp_en ? addr + 32'(c - 1) : 32'd0;
            exp_wdata = exp_we ? wdata[8 * (c - 1) +: 8] : 8'd0;
            if (c == cyc) begin exp_rdata = v; exp_err = e; end
            @(negedge sysclk);
            if (resp_valid && lat == 0) begin lat = c; rd = resp_rdata; er = resp_err; end
            @(posedge sysclk); #1;
        end
        set_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        logic        et_we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  et_f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] et_a  [4] = '{32'h101, 32'h103, 32'h100, 32'h100};
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_ready", req_ready, 32'd1);
        chk("rst_mem_en", mem_en, 32'd0);
        sysreset = 1'b1;

        xact(1'b1, 3'b010, 32'h100, 32'hA1B2C3D4, 1'b0, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd5);
        chk("sw_err", er, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_b0", mem[10'h100], 32'hD4);
        chk("sw_b1", mem[10'h101], 32'hC3);
        chk("sw_b2", mem[10'h102], 32'hB2);
        chk("sw_b3", mem[10'h103], 32'hA1);

        poke(32'h101, 8'h80);
        xact(1'b0, 3'b000, 32'h101, 32'd0, 1'b0, rd, er, lat);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        chk("lb_lat", 32'(lat), 32'd3);
        xact(1'b0, 3'b100, 32'h101, 32'd0, 1'b0, rd, er, lat);
        chk("lbu_rdata", rd, 32'h00000080);

        poke(32'h102, 8'h34);
        poke(32'h103, 8'hF2);
        xact(1'b0, 3'b001, 32'h102, 32'd0, 1'b0, rd, er, lat);
        chk("lh_rdata", rd, 32'hFFFFF234);
        chk("lh_lat", 32'(lat), 32'd4);
        xact(1'b0, 3'b101, 32'h102, 32'd0, 1'b0, rd, er, lat);
        chk("lhu_rdata", rd, 32'h0000F234);

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        xact(1'b0, 3'b010, 32'h100, 32'd0, 1'b0, rd, er, lat);
        chk("lw_rdata", rd, 32'h44332211);
        chk("lw_lat", 32'(lat), 32'd6);

        for (int i = 0; i < 4; i++) begin
            xact(et_we[i], et_f3[i], et_a[i], 32'hFFFF_FFFF, 1'b0, rd, er, lat);
            chk("err_flag", er, 32'd1);
            chk("err_rdata", rd, 32'd0);
            chk("err_lat", 32'(lat), 32'd1);
        end

        xact(1'b1, 3'b000, 32'h104, 32'h123456EE, 1'b0, rd, er, lat);
        xact(1'b0, 3'b000, 32'h104, 32'd0, 1'b0, rd, er, lat);
        chk("sb_lb_rdata", rd, 32'hFFFFFFEE);
        xact(1'b1, 3'b001, 32'h106, 32'h99997F01, 1'b0, rd, er, lat);
        xact(1'b0, 3'b001, 32'h106, 32'd0, 1'b0, rd, er, lat);
        chk("sh_lh_rdata", rd, 32'h00007F01);

        poke(32'hFFFF_FFFF, 8'h5C);
        xact(1'b0, 3'b000, 32'hFFFF_FFFF, 32'd0, 1'b0, rd, er, lat);
        chk("lb_top_rdata", rd, 32'h0000005C);

        poke(32'h300, 8'h5A); poke(32'h301, 8'h5B); poke(32'h302, 8'h5C); poke(32'h303, 8'h5D);
        chk_on = 1'b0;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'hCAFEBABE; req_valid = 1'b1;
        @(posedge sysclk); #1;
        req_valid = 1'b0;
        @(posedge sysclk); #1;
        chk("abort_pre_we", mem_we, 32'd1);
        chk("abort_pre_addr", mem_addr, 32'h301);
        sysreset = 1'b0;
        #1;
        chk("abort_mem_we", mem_we, 32'd0);
        chk("abort_mem_en", mem_en, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_ready", req_ready, 32'd1);
        chk("abort_rdata", resp_rdata, 32'd0);
        repeat (2) begin
            @(negedge sysclk);
            chk("abort_no_resp", resp_valid, 32'd0);
        end
        @(posedge sysclk); #1;
        sysreset = 1'b1;
        set_idle();
        exp_rdata = 32'd0; exp_err = 1'b0;
        chk_on = 1'b1;
        xact(1'b0, 3'b010, 32'h300, 32'd0, 1'b0, rd, er, lat);
        chk("after_abort_lw", rd, 32'h5D5C5BBE);
        chk("after_abort_lat", 32'(lat), 32'd6);

        xact(1'b1, 3'b010, 32'h200, 32'h87654321, 1'b1, rd, er, lat);
        chk("b2b_sw_lat", 32'(lat), 32'd5);
        xact(1'b0, 3'b010, 32'h200, 32'd0, 1'b1, rd, er, lat);
        chk("b2b_lw_rdata", rd, 32'h87654321);
        xact(1'b0, 3'b001, 32'h202, 32'd0, 1'b0, rd, er, lat);
        chk("b2b_lh_rdata", rd, 32'hFFFF8765);
        repeat (3) @(posedge sysclk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_byte_lsu.md
DMEM_BYTE_LSU -- requirements
Module: dmem_byte_lsu

Interface
REQ-001 sysclk  in  1  single clock; all state on rising edge.
REQ-002 sysreset  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  core requests a data-memory access.
REQ-004 req_ready  out  1  LSU can accept a request; high only in IDLE.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_funct3  in  3  RV32I load/store funct3.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, rs2 value.
REQ-009 resp_valid  out  1  one-cycle pulse on access completion.
REQ-010 resp_rdata  out  32  load result, extended to 32 bits.
REQ-011 resp_err  out  1  qualified by resp_valid; misaligned or illegal funct3.
REQ-012 mem_en  out  1  byte access strobe to the 8-bit data memory.
REQ-013 mem_we  out  1  byte write enable, dmem_we equivalent.
REQ-014 mem_addr  out  32  byte address of current access.
REQ-015 mem_wdata  out  8  byte write data.
REQ-016 mem_rdata  in  8  read byte, valid the cycle after mem_en with mem_we=0 (synchronous-read memory).

Function
REQ-017 States SHALL be IDLE, ACCESS, FIN, RESP.
REQ-018 A request SHALL be accepted at a rising edge where req_valid=1 in IDLE; req_we, req_funct3, req_addr and req_wdata SHALL be latched.
REQ-019 Byte count n SHALL be 1 for funct3[1:0]=00, 2 for 01 and 4 for 10.
REQ-020 Legal loads SHALL be 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal stores SHALL be 000, 001 and 010; every other code SHALL be illegal.
REQ-021 An access SHALL be misaligned when it is a halfword with addr[0]=1 or a word with addr[1:0]!=00.
REQ-022 An illegal or misaligned request SHALL go IDLE->RESP with no mem_en, resp_err=1 and resp_rdata=0.
REQ-023 A legal request SHALL go IDLE->ACCESS and issue bytes k=0..n-1 in consecutive cycles 1..n after acceptance, with mem_en=1, mem_addr=addr+k and mem_we=req_we.
REQ-024 Stores SHALL drive mem_wdata=wdata[8k+7:8k] (little-endian); after byte n-1 the state SHALL go ACCESS->RESP.
REQ-025 Loads SHALL capture mem_rdata into byte lane k one cycle after byte k is issued; after byte n-1 the state SHALL go ACCESS->FIN, where mem_en=0 and the last byte is captured, then FIN->RESP.
REQ-026 Latency from the accept edge to the resp_valid cycle SHALL be n+2 cycles for loads, n+1 cycles for stores and 1 cycle for errors.
REQ-027 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE; there is no back-to-back accept in RESP.
REQ-028 LB and LH SHALL sign-extend from bit 7 and bit 15 respectively; LBU and LHU SHALL zero-extend; LW SHALL pass all 32 bits.
REQ-029 Store responses SHALL have resp_rdata=0 and resp_err=0.
REQ-030 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-031 mem_en, mem_we and mem_wdata SHALL be 0 outside ACCESS, and mem_addr SHALL be 0 outside ACCESS.
REQ-032 Address arithmetic SHALL be 32-bit modulo, so 0xFFFFFFFF+1 wraps to 0; this is unreachable for aligned legal accesses.
REQ-033 req_valid outside IDLE SHALL be ignored; the requester holds its request until req_ready.

Reset
REQ-034 While sysreset=0, state SHALL be IDLE and req_ready=1; resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-035 Assertion mid-access SHALL abort the transaction immediately and asynchronously, deasserting mem_en and mem_we in the same instant with no response issued.
REQ-036 After deassertion, the first accept SHALL be possible at the first rising edge.

Verification
REQ-037 SW, addr 0x100, wdata 0xA1B2C3D4 -> cycles 1-4 write 0xD4, 0xC3, 0xB2, 0xA1 to 0x100-0x103; resp_valid in cycle 5, err=0.
REQ-038 LB from 0x101 holding 0x80 -> resp_rdata=0xFFFFFF80 in cycle 3; LBU from the same address -> 0x00000080.
REQ-039 LH from 0x102 with bytes 0x34 and 0xF2 -> resp_rdata=0xFFFFF234 in cycle 4; LW of 0x100-0x103 = 11 22 33 44 -> 0x44332211 in cycle 6.
REQ-040 LW at 0x101, SH at 0x103, or funct3=011 -> resp_err=1 in cycle 1, rdata=0, mem_en never asserted.
REQ-041 sysreset low during cycle 2 of an SW -> mem_we drops immediately, no resp_valid, req_ready=1 after release; a following LW completes correctly.
REQ-042 req_valid held high continuously -> requests accepted only in IDLE; no request lost or duplicated across 3 back-to-back transactions.
